// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester, memory and status signals of the I/D memory arbiter
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall_if;
  logic          stall_mem;
  logic          bus_err;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, bus_err
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem, bus_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one variable-latency memory port between fetch and data requesters
module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input logic          clk,
  input logic          resetn,
  mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          we_q, we_d, err_q, err_d;
  logic          busy, idle_d, idle_i, tmo_hit, done, grant_d, grant_i;
  assign busy    = state_q != IDLE;
  assign tmo_hit = busy & ~bus.mem_ready & (tmo_q == TW'(TIMEOUT - 1));
  assign done    = busy & (bus.mem_ready | tmo_hit);
  assign grant_d = bus.d_req & (~bus.i_req | (streak_q < SW'(MAX_D_STREAK)));
  assign grant_i = ~grant_d & bus.i_req;
  assign idle_d  = ~busy & grant_d;
  assign idle_i  = ~busy & grant_i;
  // state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end
  // next state: arbitrate in IDLE, return to IDLE on completion or timeout
  always_comb begin
    state_d = busy ? (done ? IDLE : state_q) : grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
  end
  // access registers, streak and timeout counters, sticky error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      streak_q <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end
  // next values; the streak can only grow while I waits, so it never exceeds MAX_D_STREAK
  always_comb begin
    streak_d = idle_d ? (bus.i_req ? streak_q + 1'b1 : '0) : idle_i ? '0 : streak_q;
    tmo_d    = (busy & ~done) ? tmo_q + 1'b1 : '0;
    addr_d   = idle_d ? bus.d_addr : idle_i ? bus.i_addr : addr_q;
    we_d     = idle_d ? bus.d_we : idle_i ? 1'b0 : we_q;
    wdata_d  = idle_d ? bus.d_wdata : wdata_q;
    err_d    = err_q | tmo_hit;
  end
  // outputs: ready and read data are combinational from the memory response
  always_comb begin
    bus.mem_req   = busy;
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.bus_err   = err_q;
    bus.i_ready   = (state_q == BUSY_I) & done;
    bus.d_ready   = (state_q == BUSY_D) & done;
    bus.i_rdata   = ((state_q == BUSY_I) & bus.mem_ready) ? bus.mem_rdata : '0;
    bus.d_rdata   = ((state_q == BUSY_D) & bus.mem_ready & ~we_q) ? bus.mem_rdata : '0;
    bus.stall_if  = bus.i_req & ~bus.i_ready;
    bus.stall_mem = bus.d_req & ~bus.d_ready;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for the I/D memory arbiter
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4), .TIMEOUT(255)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  typedef struct {
    bit          d;
    logic [31:0] addr;
    bit          we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  int ncmp = 0;
  int nmis = 0;
  int lat = 1;
  bit fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'h0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    ncmp++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  task automatic push(input bit d, input logic [31:0] addr, input bit we,
                      input logic [31:0] wdata, input logic [31:0] rdata);
    exp_t e;
    e.d = d; e.addr = addr; e.we = we; e.wdata = wdata; e.rdata = rdata;
    exp_q.push_back(e);
  endtask
  task automatic drive_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
  endtask
  task automatic drive_i(input logic [31:0] addr);
    bus.i_req = 1'b1; bus.i_addr = addr;
  endtask
  task automatic wait_rdy(input bit is_d, output int mreq, output int stall);
    mreq = 0;
    stall = 0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (bus.mem_req) mreq++;
      if (is_d ? bus.stall_mem : bus.stall_if) stall++;
      if (is_d ? bus.d_ready : bus.i_ready) begin
        @(posedge clk); #1;
        if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        return;
      end
    end
    chk(is_d ? "d_ready_wait" : "i_ready_wait", 32'd0, 32'd1);
    if (is_d) bus.d_req = 1'b0; else bus.i_req = 1'b0;
  endtask
  // memory model: ready on the lat-th BUSY cycle (lat=0 never answers)
  initial begin
    int bc;
    bc = 0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_req) begin
        bc++;
        bus.mem_ready = (lat != 0) && (bc == lat);
      end else begin
        bc = 0;
        bus.mem_ready = 1'b0;
      end
      bus.mem_rdata = !bus.mem_ready ? 32'h5A5A5A5A :
                      fixed_en ? fixed_val : {16'hC0DE, bus.mem_addr[15:0]};
    end
  end
  // monitor: every completion must match the next expected access in order
  initial forever begin
    @(negedge clk);
    if (bus.i_ready === 1'b1 || bus.d_ready === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk(e.d ? "grant_is_d" : "grant_is_i", {31'd0, bus.d_ready}, {31'd0, e.d});
        chk("mem_addr", bus.mem_addr, e.addr);
        chk("mem_we", {31'd0, bus.mem_we}, {31'd0, e.we});
        if (e.we) chk("mem_wdata", bus.mem_wdata, e.wdata);
        chk("rdata", e.d ? bus.d_rdata : bus.i_rdata, e.rdata);
      end
    end
  end
  initial begin
    int m, s, m2, s2;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0;
    bus.d_wdata = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'd0, bus.mem_req, bus.mem_we, bus.bus_err, bus.i_ready, bus.d_ready}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
    resetn = 1'b1;
    // single load, two-cycle memory
    lat = 2; fixed_en = 1; fixed_val = 32'hDEADBEEF;
    push(1, 32'h100, 0, 32'h0, 32'hDEADBEEF);
    drive_d(0, 32'h100, 32'h0);
    wait_rdy(1, m, s);
    chk("load_mem_req_cycles", m, 32'd2);
    chk("load_stall_mem_cycles", s, 32'd2);
    // simultaneous store and fetch: D first, then I
    lat = 1; fixed_en = 0;
    push(1, 32'h200, 1, 32'h12345678, 32'h0);
    push(0, 32'h0, 0, 32'h0, 32'hC0DE0000);
    drive_d(1, 32'h200, 32'h12345678);
    drive_i(32'h0);
    fork
      wait_rdy(1, m, s);
      wait_rdy(0, m2, s2);
    join
    chk("simul_stall_mem_cycles", s, 32'd1);
    chk("simul_stall_if_cycles", s2, 32'd3);
    // starvation guard: four D grants, then the waiting I, then D again
    for (int k = 0; k < 4; k++) push(1, 32'h300 + 4 * k, 0, 32'h0, 32'hC0DE0300 + 4 * k);
    push(0, 32'h80, 0, 32'h0, 32'hC0DE0080);
    push(1, 32'h310, 0, 32'h0, 32'hC0DE0310);
    push(1, 32'h314, 0, 32'h0, 32'hC0DE0314);
    drive_i(32'h80);
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          int mm, ss;
          drive_d(0, 32'h300 + 4 * k, 32'h0);
          wait_rdy(1, mm, ss);
        end
      end
      wait_rdy(0, m2, s2);
    join
    chk("starve_stall_if_cycles", s2, 32'd9);
    // mem_ready in the very cycle the timeout would fire wins
    lat = 255; fixed_en = 1; fixed_val = 32'hCAFEF00D;
    push(0, 32'h40, 0, 32'h0, 32'hCAFEF00D);
    drive_i(32'h40);
    wait_rdy(0, m, s);
    chk("coincide_mem_req_cycles", m, 32'd255);
    @(negedge clk);
    chk("coincide_bus_err", {31'd0, bus.bus_err}, 32'd0);
    // timeout: memory never answers
    lat = 0;
    push(0, 32'h44, 0, 32'h0, 32'h0);
    drive_i(32'h44);
    wait_rdy(0, m, s);
    chk("timeout_mem_req_cycles", m, 32'd255);
    @(negedge clk);
    chk("timeout_bus_err", {31'd0, bus.bus_err}, 32'd1);
    lat = 1; fixed_en = 0;
    push(1, 32'h48, 0, 32'h0, 32'hC0DE0048);
    drive_d(0, 32'h48, 32'h0);
    wait_rdy(1, m, s);
    @(negedge clk);
    chk("bus_err_sticky", {31'd0, bus.bus_err}, 32'd1);
    // reset in the middle of a D access
    lat = 0;
    drive_d(0, 32'h500, 32'h0);
    repeat (3) @(negedge clk);
    chk("pre_reset_mem_req", {31'd0, bus.mem_req}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("reset_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("reset_bus_err", {31'd0, bus.bus_err}, 32'd0);
    @(posedge clk); #1;
    lat = 2; fixed_en = 1; fixed_val = 32'h0BADF00D;
    push(1, 32'h500, 0, 32'h0, 32'h0BADF00D);
    resetn = 1'b1;
    wait_rdy(1, m, s);
    chk("post_reset_mem_req_cycles", m, 32'd2);
    repeat (2) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nmis);
    $finish;
  end
endmodule
